tacho_multi: RTL and testbench

//  Multi-channel fan tachometer for the CPLD CSR space. Counts tacho-input edges per channel over a

---
 rtl/tacho_pkg.sv | 41 ++++
 rtl/tacho_multi_if.sv | 18 +
 rtl/tacho_channel.sv | 95 +++++++++
 rtl/tacho_multi.sv | 129 ++++++++++++
 tb/tb_tacho_multi.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tacho_pkg.sv
// ============================================================================
// Module : tacho_pkg
// Brief  : Register map, CTRL field layout and readout encoding for the
//          multi-channel tachometer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tacho_pkg;

  localparam int c_ctrl_ofs     = 0;
  localparam int c_val0_ofs     = 1;

  localparam int c_gate_sel_lsb = 0;
  localparam int c_gate_sel_w   = 2;
  localparam int c_edge_sel_bit = 2;
  localparam int c_ch_en_lsb    = 4;

  function automatic int ovf_ofs(input int num_ch);
    return num_ch + 1;
  endfunction

  // Three-range encoding: exact below 128, coarse (shifted) up to 128<<shift,
  // saturated above that.
  function automatic logic [7:0] encode_val(input logic [15:0] c, input int shift);
    logic [31:0] cw;
    logic [31:0] sh;
    cw = {16'd0, c};
    sh = cw >> shift;
    if (cw < 32'd128) begin
      return {1'b0, c[6:0]};
    end else if (cw < (32'd128 << shift)) begin
      return {1'b1, sh[6:0]};
    end else begin
      return 8'hFF;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/tacho_multi_if.sv
// ============================================================================
// Module : tacho_multi_if
// Brief  : Shared 5-bit address / 8-bit data CSR bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface tacho_multi_if;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;

  modport master (output csr_a, output csr_di, output csr_we, input  csr_do);
  modport slave  (input  csr_a, input  csr_di, input  csr_we, output csr_do);
endinterface

`default_nettype wire

// File: rtl/tacho_channel.sv
// ============================================================================
// Module : tacho_channel
// Brief  : One tacho input: synchroniser, optional glitch filter
//          (TACHO_FILTER_EN), edge select, saturating counter, capture.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tacho_channel #(
  parameter int CNT_WIDTH  = 10,
  parameter int FILTER_LEN = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 tacho_i,
  input  wire logic                 en_i,
  input  wire logic                 edge_sel_i,
  input  wire logic                 gate_i,
  input  wire logic                 clr_i,
  output logic [CNT_WIDTH-1:0]      cap_o,
  output logic                      ovf_set_o
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

  logic                 sync1_q, sync2_q, prev_q;
  logic                 w_filt;
  logic                 w_edge;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cap_q, cap_d;

`ifdef TACHO_FILTER_EN
  localparam int c_fw = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic            filt_q;
  logic [c_fw-1:0] stab_q;

  // Output follows the synchronised input only after FILTER_LEN differing samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else if (sync2_q == filt_q) begin
      stab_q <= '0;
    end else if (stab_q == c_fw'(FILTER_LEN - 1)) begin
      filt_q <= sync2_q;
      stab_q <= '0;
    end else begin
      stab_q <= stab_q + 1'b1;
    end
  end

  assign w_filt = filt_q;
`else
  assign w_filt = sync2_q;
`endif

  assign w_edge    = edge_sel_i ? (prev_q & ~w_filt) : (w_filt & ~prev_q);
  assign ovf_set_o = en_i & w_edge & (cnt_q == c_cnt_max);
  assign cap_o     = cap_q;

  always_comb begin
    cnt_d = cnt_q;
    cap_d = cap_q;
    if (gate_i) begin
      cap_d = cnt_q;
    end
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (gate_i) begin
      cnt_d = w_edge ? CNT_WIDTH'(1) : '0;
    end else if (w_edge && (cnt_q != c_cnt_max)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      cap_q   <= '0;
    end else begin
      sync1_q <= tacho_i;
      sync2_q <= sync1_q;
      prev_q  <= w_filt;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tacho_multi.sv
// ============================================================================
// Module : tacho_multi
// Brief  : Multi-channel fan tachometer on the CSR bus. Optional input glitch
//          filter enabled with TACHO_FILTER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tacho_multi
  import tacho_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR   = 5'h0,
  parameter int         NUM_CH      = 2,
  parameter int         CNT_WIDTH   = 10,
  parameter int         SCALE_SHIFT = 3,
  parameter int         FILTER_LEN  = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  tacho_multi_if.slave           bus,
  input  wire logic              ce_1hz,
  input  wire logic [NUM_CH-1:0] tacho_in
);

  localparam logic [4:0] c_addr_ctrl = BASE_ADDR + 5'(c_ctrl_ofs);
  localparam logic [4:0] c_addr_ovf  = BASE_ADDR + 5'(ovf_ofs(NUM_CH));

  logic [1:0]        gate_sel_q;
  logic              edge_sel_q;
  logic [NUM_CH-1:0] ch_en_q;
  logic [2:0]        div_q, div_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;

  logic              w_ctrl_we;
  logic              w_ovf_we;
  logic              w_gate;
  logic [2:0]        w_div_last;
  logic [NUM_CH-1:0] w_ovf_set;
  logic [NUM_CH-1:0] w_ovf_clr;
  logic [7:0]        w_ctrl_img;
  logic [7:0]        w_rdata;
  logic              w_unused_di;

  logic [CNT_WIDTH-1:0] w_cap [NUM_CH];
  logic [7:0]           w_val [NUM_CH];

  assign w_ctrl_we   = bus.csr_we && (bus.csr_a == c_addr_ctrl);
  assign w_ovf_we    = bus.csr_we && (bus.csr_a == c_addr_ovf);
  assign w_unused_di = ^bus.csr_di;

  // Divider terminal count is 2^gate_sel - 1; the 3-bit wrap yields 7 for gate_sel=3.
  assign w_div_last = (3'b001 << gate_sel_q) - 3'b001;
  assign w_gate     = ce_1hz && (div_q == w_div_last);

  always_comb begin
    div_d = div_q;
    if (w_ctrl_we || w_gate) begin
      div_d = '0;
    end else if (ce_1hz) begin
      div_d = div_q + 3'b001;
    end
  end

  assign w_ovf_clr = w_ovf_we ? bus.csr_di[NUM_CH-1:0] : '0;
  assign ovf_d     = (ovf_q & ~w_ovf_clr) | w_ovf_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_sel_q <= '0;
      edge_sel_q <= 1'b0;
      ch_en_q    <= '0;
      div_q      <= '0;
      ovf_q      <= '0;
    end else begin
      if (w_ctrl_we) begin
        gate_sel_q <= bus.csr_di[c_gate_sel_lsb +: c_gate_sel_w];
        edge_sel_q <= bus.csr_di[c_edge_sel_bit];
        ch_en_q    <= bus.csr_di[c_ch_en_lsb +: NUM_CH];
      end
      div_q <= div_d;
      ovf_q <= ovf_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tacho_channel #(
      .CNT_WIDTH  (CNT_WIDTH),
      .FILTER_LEN (FILTER_LEN)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tacho_i    (tacho_in[i]),
      .en_i       (ch_en_q[i]),
      .edge_sel_i (edge_sel_q),
      .gate_i     (w_gate),
      .clr_i      (w_ctrl_we),
      .cap_o      (w_cap[i]),
      .ovf_set_o  (w_ovf_set[i])
    );
    assign w_val[i] = encode_val(16'(w_cap[i]), SCALE_SHIFT);
  end

  always_comb begin
    w_ctrl_img                                 = '0;
    w_ctrl_img[c_gate_sel_lsb +: c_gate_sel_w] = gate_sel_q;
    w_ctrl_img[c_edge_sel_bit]                 = edge_sel_q;
    w_ctrl_img[c_ch_en_lsb +: NUM_CH]          = ch_en_q;
  end

  always_comb begin
    w_rdata = '0;
    if (bus.csr_a == c_addr_ctrl) begin
      w_rdata = w_ctrl_img;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.csr_a == BASE_ADDR + 5'(c_val0_ofs + i)) begin
        w_rdata = w_val[i];
      end
    end
    if (bus.csr_a == c_addr_ovf) begin
      w_rdata[NUM_CH-1:0] = ovf_q;
    end
  end

  assign bus.csr_do = w_rdata;

endmodule

`default_nettype wire

// File: tb/tb_tacho_multi.sv
// ============================================================================
// Module : tb_tacho_multi
// Brief  : Self-checking bench for tacho_multi against a count-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tacho_multi;

  localparam int         NUM_CH = 2;
  localparam int         CW     = 10;
  localparam int         SS     = 3;
  localparam int         FL     = 4;
  localparam logic [4:0] BASE   = 5'h0;
`ifdef TACHO_FILTER_EN
  localparam int LAT  = 3 + FL;
  localparam int MINW = FL + 1;
`else
  localparam int LAT  = 3;
  localparam int MINW = 1;
`endif
  localparam int CMAX   = (1 << CW) - 1;
  localparam int A_CTRL = 0;
  localparam int A_VAL0 = 1;
  localparam int A_OVF  = NUM_CH + 1;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              ce    = 1'b0;
  logic [NUM_CH-1:0] tin   = '0;

  tacho_multi_if bus();

  tacho_multi #(
    .BASE_ADDR   (BASE),
    .NUM_CH      (NUM_CH),
    .CNT_WIDTH   (CW),
    .SCALE_SHIFT (SS),
    .FILTER_LEN  (FL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .ce_1hz   (ce),
    .tacho_in (tin)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int got;

  function automatic int ref_enc(input int c);
    if (c < 128) return c;
    if (c < 128 * (2 ** SS)) return 128 + c / (2 ** SS);
    return 255;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input int a, input int d);
    bus.csr_a  = 5'(a);
    bus.csr_di = 8'(d);
    bus.csr_we = 1'b1;
    tick();
    bus.csr_we = 1'b0;
  endtask

  task automatic csr_rd(input int a, output int d);
    bus.csr_a = 5'(a);
    #1;
    d = int'(bus.csr_do);
  endtask

  task automatic settle();
    repeat (LAT + 2) tick();
  endtask

  task automatic gate();
    ce = 1'b1;
    tick();
    ce = 1'b0;
  endtask

  task automatic pulse(input int ch, input int n);
    repeat (n) begin
      tin[ch] = 1'b1;
      repeat ($urandom_range(MINW, MINW + 1)) tick();
      tin[ch] = 1'b0;
      repeat ($urandom_range(MINW, MINW + 1)) tick();
    end
  endtask

  task automatic test_reset();
    bus.csr_a = '0; bus.csr_di = '0; bus.csr_we = 1'b0;
    repeat (3) tick();
    for (int a = 0; a <= NUM_CH + 2; a++) begin
      csr_rd(a, got);
      n_checks++;
      if (got !== 0) $display("FAIL reset_addr%0d: got 0x%02h expected 0x00", a, got);
      else n_pass++;
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ctrl_rw();
    csr_wr(A_CTRL, 8'hFF);
    csr_rd(A_CTRL, got);
    n_checks++;
    if (got !== 8'h37) $display("FAIL ctrl_readback: got 0x%02h expected 0x37", got);
    else n_pass++;
  endtask

  task automatic test_basic();
    csr_wr(A_CTRL, 8'h10);
    pulse(0, 100);
    settle();
    gate();
    csr_rd(A_VAL0, got);
    n_checks++;
    if (got !== ref_enc(100)) $display("FAIL basic_val0: got 0x%02h expected 0x%02h", got, ref_enc(100));
    else n_pass++;
    csr_rd(A_VAL0 + 1, got);
    n_checks++;
    if (got !== 0) $display("FAIL basic_val1_disabled: got 0x%02h expected 0x00", got);
    else n_pass++;
    csr_rd(A_OVF, got);
    n_checks++;
    if (got !== 0) $display("FAIL basic_ovf: got 0x%02h expected 0x00", got);
    else n_pass++;
  endtask

  task automatic test_scale();
    csr_wr(A_CTRL, 8'h10);
    pulse(0, 1000);
    settle();
    gate();
    csr_rd(A_VAL0, got);
    n_checks++;
    if (got !== 8'hFD) $display("FAIL scale_1000: got 0x%02h expected 0xfd", got);
    else n_pass++;
    pulse(0, 1024);
    settle();
    gate();
    csr_rd(A_VAL0, got);
    n_checks++;
    if (got !== ref_enc(CMAX)) $display("FAIL scale_sat: got 0x%02h expected 0x%02h", got, ref_enc(CMAX));
    else n_pass++;
    csr_rd(A_OVF, got);
    n_checks++;
    if (got !== 1) $display("FAIL scale_ovf: got 0x%02h expected 0x01", got);
    else n_pass++;
  endtask

  task automatic test_ovf_w1c();
    csr_wr(A_OVF, 8'h01);
    csr_rd(A_OVF, got);
    n_checks++;
    if (got !== 0) $display("FAIL ovf_clear: got 0x%02h expected 0x00", got);
    else n_pass++;
    csr_wr(A_CTRL, 8'h10);
    pulse(0, CMAX);
    settle();
    csr_rd(A_OVF, got);
    n_checks++;
    if (got !== 0) $display("FAIL ovf_at_max: got 0x%02h expected 0x00", got);
    else n_pass++;
    // The overflowing edge lands on the same clock as the clearing write.
    tin[0] = 1'b1;
    repeat (LAT - 1) tick();
    csr_wr(A_OVF, 8'h01);
    csr_rd(A_OVF, got);
    n_checks++;
    if (got !== 1) $display("FAIL ovf_set_wins: got 0x%02h expected 0x01", got);
    else n_pass++;
    tin[0] = 1'b0;
    settle();
    gate();
    csr_rd(A_VAL0, got);
    n_checks++;
    if (got !== 8'hFF) $display("FAIL ovf_val0: got 0x%02h expected 0xff", got);
    else n_pass++;
    csr_wr(A_OVF, 8'h03);
  endtask

  task automatic test_gate_div();
    int n_k;
    csr_wr(A_CTRL, 8'h30);
    gate();
    csr_wr(A_CTRL, 8'h32);
    for (int k = 0; k < 4; k++) begin
      n_k = (k < 2) ? 13 : 12;
      pulse(1, n_k);
      settle();
      gate();
      csr_rd(A_VAL0 + 1, got);
      n_checks++;
      if (k < 3) begin
        if (got !== 0) $display("FAIL gate4_early%0d: got 0x%02h expected 0x00", k, got);
        else n_pass++;
      end else begin
        if (got !== ref_enc(50)) $display("FAIL gate4_val1: got 0x%02h expected 0x%02h", got, ref_enc(50));
        else n_pass++;
      end
    end
  endtask

  task automatic test_gate_edge();
    csr_wr(A_CTRL, 8'h10);
    pulse(0, 9);
    settle();
    tin[0] = 1'b1;
    repeat (LAT - 1) tick();
    gate();
    csr_rd(A_VAL0, got);
    n_checks++;
    if (got !== 9) $display("FAIL gate_edge_first: got 0x%02h expected 0x09", got);
    else n_pass++;
    tin[0] = 1'b0;
    settle();
    gate();
    csr_rd(A_VAL0, got);
    n_checks++;
    if (got !== 1) $display("FAIL gate_edge_next: got 0x%02h expected 0x01", got);
    else n_pass++;
  endtask

  task automatic test_random();
    int en, es, ncyc, exp_ovf, c, nv;
    int n [NUM_CH];
    int hold [NUM_CH];
    for (int it = 0; it < 4; it++) begin
      en = $urandom_range(0, 3);
      es = $urandom_range(0, 1);
      csr_wr(A_CTRL, (en << 4) | (es << 2));
      for (int ch = 0; ch < NUM_CH; ch++) begin
        n[ch] = 0;
        hold[ch] = MINW;
      end
      ncyc = $urandom_range(100, 2400);
      repeat (ncyc) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (hold[ch] >= MINW && $urandom_range(0, 3) != 0) begin
            nv = tin[ch] ? 0 : 1;
            tin[ch] = nv[0];
            if ((es == 0 && nv == 1) || (es == 1 && nv == 0)) n[ch]++;
            hold[ch] = 0;
          end
        end
        tick();
        for (int ch = 0; ch < NUM_CH; ch++) hold[ch]++;
      end
      settle();
      gate();
      exp_ovf = 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        c = 0;
        if (((en >> ch) & 1) != 0) begin
          c = (n[ch] > CMAX) ? CMAX : n[ch];
          if (n[ch] > CMAX) exp_ovf |= (1 << ch);
        end
        csr_rd(A_VAL0 + ch, got);
        n_checks++;
        if (got !== ref_enc(c))
          $display("FAIL rand%0d_val%0d: got 0x%02h expected 0x%02h (edges %0d)", it, ch, got, ref_enc(c), n[ch]);
        else n_pass++;
      end
      csr_rd(A_OVF, got);
      n_checks++;
      if (got !== exp_ovf) $display("FAIL rand%0d_ovf: got 0x%02h expected 0x%02h", it, got, exp_ovf);
      else n_pass++;
      csr_wr(A_OVF, 8'h03);
    end
    tin = '0;
    settle();
  endtask

`ifdef TACHO_FILTER_EN
  task automatic test_filter();
    csr_wr(A_CTRL, 8'h10);
    repeat (5) begin
      tin[0] = 1'b1; repeat (3) tick();
      tin[0] = 1'b0; repeat (FL + 2) tick();
    end
    settle();
    gate();
    csr_rd(A_VAL0, got);
    n_checks++;
    if (got !== 0) $display("FAIL filter_glitch: got 0x%02h expected 0x00", got);
    else n_pass++;
    repeat (5) begin
      tin[0] = 1'b1; repeat (5) tick();
      tin[0] = 1'b0; repeat (FL + 2) tick();
    end
    settle();
    gate();
    csr_rd(A_VAL0, got);
    n_checks++;
    if (got !== 5) $display("FAIL filter_pulse: got 0x%02h expected 0x05", got);
    else n_pass++;
  endtask
`endif

  task automatic test_async_reset();
    csr_wr(A_CTRL, 8'h31);
    pulse(0, 20);
    #3;
    rst_n = 1'b0;
    #1;
    for (int a = 0; a <= NUM_CH + 1; a++) begin
      csr_rd(a, got);
      n_checks++;
      if (got !== 0) $display("FAIL async_rst_addr%0d: got 0x%02h expected 0x00", a, got);
      else n_pass++;
    end
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    csr_wr(A_CTRL, 8'h10);
    pulse(0, 20);
    settle();
    gate();
    csr_rd(A_VAL0, got);
    n_checks++;
    if (got !== 20) $display("FAIL post_rst_val0: got 0x%02h expected 0x14", got);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ctrl_rw();
    test_basic();
    test_scale();
    test_ovf_w1c();
    test_gate_div();
    test_gate_edge();
    test_random();
`ifdef TACHO_FILTER_EN
    test_filter();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
